// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// iteration count and a magnitude helper.
package muldiv_pkg;

   localparam int XLEN = 32;
   localparam int ITER = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Two's-complement magnitude when neg is set, raw value otherwise.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
      mag = neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final result shaping: applies sign correction to the unsigned iteration result
// and substitutes the divide-by-zero result.
module muldiv_signfix
   import muldiv_pkg::*;
(
   input  logic            is_div,
   input  logic            neg_res,
   input  logic            neg_rem,
   input  logic            div_zero,
   input  logic [XLEN-1:0] a_orig,
   input  logic [63:0]     prod,
   input  logic [XLEN-1:0] quot,
   input  logic [XLEN-1:0] rem,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   logic [63:0] prod_fix;

   always_comb begin
      prod_fix = neg_res ? (~prod + 64'd1) : prod;
      hi       = prod_fix[63:32];
      lo       = prod_fix[31:0];
      if (is_div) begin
         if (div_zero) begin
            lo = '1;
            hi = a_orig;
         end else begin
            lo = mag(quot, neg_res);
            hi = mag(rem, neg_rem);
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFHI/MFLO
// read mux; holds busy high for the pipeline to stall while an operation runs.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic            sel_hi,
   output logic [XLEN-1:0] hilo_q,
   output logic            busy,
   output logic            done
);

   state_t          state_reg, state_next;
   logic [4:0]      count_reg;
   logic [63:0]     acc_reg;
   logic [XLEN-1:0] opnd_reg;
   logic [XLEN-1:0] rem_reg;
   logic [XLEN-1:0] a_orig_reg;
   logic            is_div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;
   logic [XLEN-1:0] hi_reg, lo_reg;
   logic            done_reg;

   logic            is_signed, sign_a, sign_b;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [32:0]     sum, shifted, diff;
   logic            ge;
   logic [XLEN-1:0] fix_hi, fix_lo;

   assign is_signed = ~op[0];
   assign sign_a    = is_signed & a[XLEN-1];
   assign sign_b    = is_signed & b[XLEN-1];
   assign a_mag     = mag(a, sign_a);
   assign b_mag     = mag(b, sign_b);

   // Multiply step: add multiplicand into the upper half when the current multiplier bit is set.
   assign sum     = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
   // Divide step: shift in the next dividend bit; a set bit 32 of shifted always fits the divisor.
   assign shifted = {rem_reg, acc_reg[31]};
   assign diff    = shifted - {1'b0, opnd_reg};
   assign ge      = shifted[32] | ~diff[32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (count_reg == 5'(ITER - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
      done = done_reg;
   end

   muldiv_signfix u_signfix (
      .is_div   (is_div_reg),
      .neg_res  (neg_res_reg),
      .neg_rem  (neg_rem_reg),
      .div_zero (div_zero_reg),
      .a_orig   (a_orig_reg),
      .prod     (acc_reg),
      .quot     (acc_reg[31:0]),
      .rem      (rem_reg),
      .hi       (fix_hi),
      .lo       (fix_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= '0;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         rem_reg      <= '0;
         a_orig_reg   <= '0;
         is_div_reg   <= 1'b0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div_zero_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= (state_reg == FIX);
         case (state_reg)
            IDLE: begin
               if (start) begin
                  count_reg    <= '0;
                  is_div_reg   <= op[1];
                  neg_res_reg  <= sign_a ^ sign_b;
                  neg_rem_reg  <= sign_a;
                  div_zero_reg <= (b == '0);
                  a_orig_reg   <= a;
                  rem_reg      <= '0;
                  if (op[1]) begin
                     acc_reg  <= {32'd0, a_mag};
                     opnd_reg <= b_mag;
                  end else begin
                     acc_reg  <= {32'd0, b_mag};
                     opnd_reg <= a_mag;
                  end
               end else begin
                  if (mthi) hi_reg <= a;
                  if (mtlo) lo_reg <= a;
               end
            end
            RUN: begin
               count_reg <= count_reg + 5'd1;
               if (is_div_reg) begin
                  acc_reg[31:0] <= {acc_reg[30:0], ge};
                  rem_reg       <= ge ? diff[31:0] : shifted[31:0];
               end else begin
                  acc_reg <= {sum, acc_reg[31:1]};
               end
            end
            FIX: begin
               hi_reg <= fix_hi;
               lo_reg <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign hilo_q = sel_hi ? hi_reg : lo_reg;

endmodule
